// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 load/store funct3 codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/lane shift, load extraction/extension,
// and the fault decode for misaligned or unsupported accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       off,
    input  logic             rden,
    input  logic             wren,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       wmask,
    output logic [WIDTH-1:0] wdata_lanes,
    output logic [WIDTH-1:0] rdata_ext,
    output logic             fault
);

    logic [4:0]       shamt;
    logic [WIDTH-1:0] word;
    logic             misalign;
    logic             bad_load;
    logic             bad_store;

    always_comb begin
        shamt       = {off, 3'b000};
        wdata_lanes = wdata << shamt;
        word        = rdata >> shamt;

        wmask = '0;
        case (funct3[1:0])
            2'b00:   wmask = 4'b0001 << off;
            2'b01:   wmask = 4'b0011 << off;
            2'b10:   wmask = 4'b1111;
            default: wmask = '0;
        endcase

        misalign = ((funct3[1:0] == 2'b01) && off[0])
                || ((funct3[1:0] == 2'b10) && (off != 2'b00));

        rdata_ext = '0;
        bad_load  = 1'b0;
        case (funct3)
            F3_LB:   rdata_ext = {{(WIDTH-8){word[7]}}, word[7:0]};
            F3_LH:   rdata_ext = {{(WIDTH-16){word[15]}}, word[15:0]};
            F3_LW:   rdata_ext = word;
            F3_LBU:  rdata_ext = {{(WIDTH-8){1'b0}}, word[7:0]};
            F3_LHU:  rdata_ext = {{(WIDTH-16){1'b0}}, word[15:0]};
            F3_LWU:  rdata_ext = word;
            default: bad_load  = 1'b1;
        endcase

        bad_store = !((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));

        fault = (rden && wren)
             || (rden && (bad_load || misalign))
             || (wren && (bad_store || misalign));
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EXU operation, runs a req/ack word access to data
// memory, and returns extended load data or a fault to the write-back stage.
module lsu
    import lsu_pkg::*;
#(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_rden,
    input  logic                 i_wren,
    input  logic [2:0]           i_funct3,
    input  logic [CPU_WIDTH-1:0] i_addr,
    input  logic [CPU_WIDTH-1:0] i_wdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_wmask,
    input  logic                 i_mem_ack,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata,
    output logic                 o_valid,
    input  logic                 i_wbu_ready,
    output logic [CPU_WIDTH-1:0] o_rdata,
    output logic                 o_fault
);

    lsu_state_t state, state_next;

    logic [2:0]           funct3_q;
    logic [1:0]           off_q;
    logic                 load_q;
    logic [2:0]           sel_funct3;
    logic [1:0]           sel_off;
    logic [3:0]           al_wmask;
    logic [CPU_WIDTH-1:0] al_wdata;
    logic [CPU_WIDTH-1:0] al_rdata;
    logic                 al_fault;
    logic                 accept;
    logic                 mem_op;

    assign accept = i_valid && (state == ST_IDLE);
    assign mem_op = i_rden || i_wren;

    // One align instance serves both phases: live inputs while idle (request
    // decode), latched funct3/offset afterwards (load formatting on ack).
    assign sel_funct3 = (state == ST_IDLE) ? i_funct3    : funct3_q;
    assign sel_off    = (state == ST_IDLE) ? i_addr[1:0] : off_q;

    lsu_align #(
        .WIDTH (CPU_WIDTH)
    ) u_align (
        .funct3      (sel_funct3),
        .off         (sel_off),
        .rden        (i_rden),
        .wren        (i_wren),
        .wdata       (i_wdata),
        .rdata       (i_mem_rdata),
        .wmask       (al_wmask),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .fault       (al_fault)
    );

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_mem_req  = 1'b0;
        o_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (accept) begin
                    if (!mem_op || al_fault) state_next = ST_RESP;
                    else                     state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) state_next = ST_RESP;
            end
            ST_RESP: begin
                o_valid = 1'b1;
                if (i_wbu_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            load_q      <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wmask <= '0;
            o_rdata     <= '0;
            o_fault     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                funct3_q <= i_funct3;
                off_q    <= i_addr[1:0];
                load_q   <= i_rden;
                o_rdata  <= '0;
                o_fault  <= al_fault;
                if (mem_op && !al_fault) begin
                    o_mem_we    <= i_wren;
                    o_mem_addr  <= {i_addr[CPU_WIDTH-1:2], 2'b00};
                    o_mem_wdata <= al_wdata;
                    o_mem_wmask <= i_wren ? al_wmask : 4'b0000;
                end
            end
            if ((state == ST_REQ) && i_mem_ack && load_q) begin
                o_rdata <= al_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed operations with a result scoreboard,
// memory/WBU handshake timing, reset abandonment and back-to-back issue.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_rden = 1'b0;
    logic        i_wren = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_valid;
    logic        i_wbu_ready = 1'b0;
    logic [31:0] o_rdata;
    logic        o_fault;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    lsu #(.CPU_WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_rden      (i_rden),
        .i_wren      (i_wren),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wmask (o_mem_wmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_valid     (o_valid),
        .i_wbu_ready (i_wbu_ready),
        .o_rdata     (o_rdata),
        .o_fault     (o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference behaviour written per byte lane rather than by shifting.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, output logic flt,
                                  output logic [31:0] rdata, output logic [3:0] mask,
                                  output logic [31:0] mwd);
        int off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(addr[1:0]);
        flt = 1'b0; rdata = '0; mask = '0; mwd = '0;
        if (!rd && !wr) return;
        if (rd && wr) begin
            flt = 1'b1;
        end else if (rd) begin
            case (f3)
                3'b000, 3'b100: begin
                    b = word[8*off +: 8];
                    rdata = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
                end
                3'b001, 3'b101: begin
                    if (addr[0]) flt = 1'b1;
                    else begin
                        h = addr[1] ? word[31:16] : word[15:0];
                        rdata = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
                    end
                end
                3'b010, 3'b110: begin
                    if (addr[1:0] != 2'b00) flt = 1'b1;
                    else rdata = word;
                end
                default: flt = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000: begin
                    mask = 4'(1 << off);
                    mwd[8*off +: 8] = wdata[7:0];
                end
                3'b001: begin
                    if (addr[0]) flt = 1'b1;
                    else begin
                        mask = addr[1] ? 4'b1100 : 4'b0011;
                        mwd[8*off +: 16] = wdata[15:0];
                    end
                end
                3'b010: begin
                    if (addr[1:0] != 2'b00) flt = 1'b1;
                    else begin
                        mask = 4'b1111;
                        mwd = wdata;
                    end
                end
                default: flt = 1'b1;
            endcase
        end
    endfunction

    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                         input int ack_dly, input int rdy_dly);
        logic        flt;
        logic [31:0] erd, emw, lanes;
        logic [3:0]  emask;
        logic [32:0] e;
        int          t;
        model(rd, wr, f3, addr, wdata, word, flt, erd, emask, emw);
        lanes = {{8{emask[3]}}, {8{emask[2]}}, {8{emask[1]}}, {8{emask[0]}}};
        exp_q.push_back({flt, erd});

        @(negedge i_clk);
        i_valid = 1'b1; i_rden = rd; i_wren = wr; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        t = 0;
        while (!o_ready && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0; i_rden = 1'b0; i_wren = 1'b0; i_addr = 32'hFFFF_FFFF; i_wdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        check({tag, "_busy"}, 32'(o_ready), 32'd0);

        if (!flt && (rd || wr)) begin
            for (int c = 0; c <= ack_dly; c++) begin
                check({tag, "_req"}, 32'(o_mem_req), 32'd1);
                check({tag, "_we"}, 32'(o_mem_we), 32'(wr));
                check({tag, "_maddr"}, o_mem_addr, addr & ~32'd3);
                check({tag, "_vbusy"}, 32'(o_valid), 32'd0);
                if (wr) begin
                    check({tag, "_wmask"}, 32'(o_mem_wmask), 32'(emask));
                    check({tag, "_wdata"}, o_mem_wdata & lanes, emw);
                end
                if (c == ack_dly) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = word;
                end
                @(posedge i_clk);
                #1;
                i_mem_ack = 1'b0;
                i_mem_rdata = 32'hDEAD_BEEF;
                @(negedge i_clk);
            end
        end else begin
            check({tag, "_noreq"}, 32'(o_mem_req), 32'd0);
        end

        for (int c = 0; c <= rdy_dly; c++) begin
            e = exp_q[0];
            check({tag, "_valid"}, 32'(o_valid), 32'd1);
            check({tag, "_rdata"}, o_rdata, e[31:0]);
            check({tag, "_fault"}, 32'(o_fault), 32'(e[32]));
            check({tag, "_reqoff"}, 32'(o_mem_req), 32'd0);
            if (c == rdy_dly) begin
                i_wbu_ready = 1'b1;
                void'(exp_q.pop_front());
            end
            @(posedge i_clk);
            #1;
            i_wbu_ready = 1'b0;
            @(negedge i_clk);
        end
        check({tag, "_idle"}, 32'(o_ready), 32'd1);
        check({tag, "_vdone"}, 32'(o_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_req"}, 32'(o_mem_req), 32'd0);
        check({tag, "_we"}, 32'(o_mem_we), 32'd0);
        check({tag, "_maddr"}, o_mem_addr, 32'd0);
        check({tag, "_mwdata"}, o_mem_wdata, 32'd0);
        check({tag, "_wmask"}, 32'(o_mem_wmask), 32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_rdata"}, o_rdata, 32'd0);
        check({tag, "_fault"}, 32'(o_fault), 32'd0);
    endtask

    initial begin
        int got;
        logic [32:0] e;

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("rst");

        do_op("sb",    1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 32'h0, 0, 0);
        do_op("lb",    1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 0);
        do_op("lbu",   1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 0);
        do_op("lh_mis",1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 0, 0);
        do_op("lw_mis",1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0);
        do_op("ld011", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        do_op("lw_bp", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 5, 3);
        do_op("noop",  1'b0, 1'b0, 3'b111, 32'h8000_0001, 32'h5555_5555, 32'h0, 0, 0);
        do_op("rdwr",  1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        do_op("sh",    1'b0, 1'b1, 3'b001, 32'h8000_0006, 32'hAAAA_BEEF, 32'h0, 1, 0);
        do_op("sw",    1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h0BAD_C0DE, 32'h0, 2, 1);
        do_op("lh",    1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h9234_0000, 0, 0);
        do_op("lhu",   1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h9234_0000, 0, 0);
        do_op("lwu",   1'b1, 1'b0, 3'b110, 32'h8000_0004, 32'h0, 32'h8765_4321, 0, 0);
        do_op("lb3",   1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_7F00, 0, 0);
        do_op("st011", 1'b0, 1'b1, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
        do_op("sw_mis",1'b0, 1'b1, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0);

        // Reset while a load is waiting for ack, then a stray ack in IDLE.
        @(negedge i_clk);
        i_valid = 1'b1; i_rden = 1'b1; i_funct3 = 3'b010; i_addr = 32'h8000_0020;
        @(posedge i_clk);
        #1 i_valid = 1'b0; i_rden = 1'b0;
        @(negedge i_clk);
        check("rstreq_req", 32'(o_mem_req), 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h1111_2222;
        @(negedge i_clk);
        check_reset_outputs("rstreq");
        @(posedge i_clk);
        #1 i_mem_ack = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("stray");
        do_op("lw_after", 1'b1, 1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h2468_ACE0, 0, 0);

        // Back-to-back loads with i_valid held high throughout.
        got = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    logic        f;
                    logic [31:0] r, w;
                    logic [3:0]  m;
                    int          t;
                    @(negedge i_clk);
                    if (k > 0) check("b2b_hold", 32'(o_ready), 32'd0);
                    i_valid = 1'b1; i_rden = 1'b1; i_wren = 1'b0; i_funct3 = 3'b010;
                    i_addr = 32'h0000_1000 + 32'(4 * k);
                    model(1'b1, 1'b0, 3'b010, i_addr, 32'h0, i_addr ^ 32'h5A5A_0000, f, r, m, w);
                    exp_q.push_back({f, r});
                    t = 0;
                    while (!o_ready && t < 30) begin
                        @(negedge i_clk);
                        t++;
                    end
                    @(posedge i_clk);
                end
                @(negedge i_clk);
                i_valid = 1'b0; i_rden = 1'b0;
            end
            begin
                repeat (80) begin
                    @(negedge i_clk);
                    i_mem_ack = o_mem_req;
                    i_mem_rdata = o_mem_addr ^ 32'h5A5A_0000;
                end
                i_mem_ack = 1'b0;
            end
            begin
                i_wbu_ready = 1'b1;
                repeat (80) begin
                    @(negedge i_clk);
                    if (o_valid) begin
                        got++;
                        check("b2b_rbusy", 32'(o_ready), 32'd0);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("b2b_rdata", o_rdata, e[31:0]);
                            check("b2b_fault", 32'(o_fault), 32'(e[32]));
                        end else begin
                            check("b2b_extra", 32'(got), 32'd4);
                        end
                    end
                end
                i_wbu_ready = 1'b0;
            end
        join
        check("b2b_count", 32'(got), 32'd4);
        check("b2b_qempty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
